// File: rtl/spi_instruction_controller.sv
// SPI frame decoder: assembles addr/instr/data frames, validates them and
// drives configuration-memory reads, writes and reload strobes.
module spi_instruction_controller #(
   parameter int MEM_DEPTH      = 164,
   parameter int CLK_DIV_ADDR   = 6,
   parameter int DEBUG_ADDR     = 163,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic       system_clock,
   input  logic       rst_n,
   input  logic       byte_valid,
   input  logic [7:0] byte_in,
   input  logic [7:0] mem_rdata,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   output logic       mem_we,
   output logic       mem_re,
   output logic [7:0] tx_byte,
   output logic       tx_load,
   output logic       clk_div_we,
   output logic       input_update,
   output logic       debug_we,
   output logic       spi_instruction_done,
   output logic       instr_error,
   output logic       frame_abort
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] GAP_MAX = CW'(TIMEOUT_CYCLES);
   localparam logic [8:0] DEPTH   = 9'(MEM_DEPTH);
   localparam logic [7:0] CD_ADDR = 8'(CLK_DIV_ADDR);
   localparam logic [7:0] DB_ADDR = 8'(DEBUG_ADDR);

   localparam logic [7:0] OP_RD = 8'h00;
   localparam logic [7:0] OP_WR = 8'h01;
   localparam logic [7:0] OP_CD = 8'h05;
   localparam logic [7:0] OP_IU = 8'h07;
   localparam logic [7:0] OP_DB = 8'h09;

   typedef enum logic [2:0] {
      S_MSB,
      S_LSB,
      S_INSTR,
      S_DATA,
      S_EXEC
   } state_t;

   state_t        state;
   logic [CW-1:0] gap;
   logic [7:0]    op_q;
   logic          err_q;
   logic          rd_wait;
   logic          op_bad;
   logic          frame_bad;
   logic          timeout;

   // mem_addr already holds the frame's LSB while the opcode is decoded
   always_comb begin
      op_bad = 1'b0;
      unique case (1'b1)
         (byte_in == OP_RD),
         (byte_in == OP_WR),
         (byte_in == OP_IU): op_bad = 1'b0;
         (byte_in == OP_CD): op_bad = (mem_addr != CD_ADDR);
         (byte_in == OP_DB): op_bad = (mem_addr != DB_ADDR);
         default:            op_bad = 1'b1;
      endcase
   end

   assign frame_bad = op_bad || ({1'b0, mem_addr} >= DEPTH);
   assign timeout   = (state inside {S_LSB, S_INSTR, S_DATA})
                    && (gap == GAP_MAX) && !byte_valid;

   always_ff @(posedge system_clock or negedge rst_n) begin
      if (!rst_n) begin
         state                <= S_MSB;
         gap                  <= '0;
         op_q                 <= '0;
         err_q                <= 1'b0;
         rd_wait              <= 1'b0;
         mem_addr             <= '0;
         mem_wdata            <= '0;
         mem_we               <= 1'b0;
         mem_re               <= 1'b0;
         tx_byte              <= '0;
         tx_load              <= 1'b0;
         clk_div_we           <= 1'b0;
         input_update         <= 1'b0;
         debug_we             <= 1'b0;
         spi_instruction_done <= 1'b0;
         instr_error          <= 1'b0;
         frame_abort          <= 1'b0;
      end else begin
         mem_we               <= 1'b0;
         mem_re               <= 1'b0;
         tx_load              <= 1'b0;
         clk_div_we           <= 1'b0;
         input_update         <= 1'b0;
         debug_we             <= 1'b0;
         spi_instruction_done <= 1'b0;
         instr_error          <= 1'b0;
         frame_abort          <= 1'b0;

         // read data arrives one cycle after mem_re
         rd_wait <= mem_re;
         if (rd_wait) begin
            tx_byte <= mem_rdata;
            tx_load <= 1'b1;
         end

         if (byte_valid || state == S_MSB)
            gap <= '0;
         else if (gap != GAP_MAX)
            gap <= gap + 1'b1;

         if (timeout) begin
            state       <= S_MSB;
            frame_abort <= 1'b1;
         end else begin
            unique case (state)
               S_MSB: begin
                  if (byte_valid)
                     state <= S_LSB;
               end
               S_LSB: begin
                  if (byte_valid) begin
                     mem_addr <= byte_in;
                     state    <= S_INSTR;
                  end
               end
               S_INSTR: begin
                  if (byte_valid) begin
                     op_q   <= byte_in;
                     err_q  <= frame_bad;
                     mem_re <= !frame_bad && (byte_in == OP_RD);
                     state  <= S_DATA;
                  end
               end
               S_DATA: begin
                  if (byte_valid) begin
                     spi_instruction_done <= 1'b1;
                     instr_error          <= err_q;
                     if (!err_q && op_q != OP_RD) begin
                        mem_wdata <= byte_in;
                        mem_we    <= 1'b1;
                     end
                     clk_div_we   <= !err_q && (op_q == OP_CD);
                     input_update <= !err_q && (op_q == OP_IU);
                     debug_we     <= !err_q && (op_q == OP_DB);
                     state        <= S_EXEC;
                  end
               end
               S_EXEC: begin
                  state <= byte_valid ? S_LSB : S_MSB;
               end
               default: state <= S_MSB;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_instruction_controller.sv
// Directed bench for spi_instruction_controller: frame table, timeout,
// back-to-back frames and mid-frame reset.
module tb_spi_instruction_controller;

   localparam int TMO = 1023;

   logic       system_clock = 1'b0;
   logic       rst_n = 1'b0;
   logic       byte_valid = 1'b0;
   logic [7:0] byte_in = '0;
   logic [7:0] mem_rdata = '0;
   logic [7:0] mem_addr, mem_wdata, tx_byte;
   logic       mem_we, mem_re, tx_load;
   logic       clk_div_we, input_update, debug_we;
   logic       spi_instruction_done, instr_error, frame_abort;

   spi_instruction_controller dut (
      .system_clock(system_clock), .rst_n(rst_n),
      .byte_valid(byte_valid), .byte_in(byte_in),
      .mem_rdata(mem_rdata), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .tx_byte(tx_byte), .tx_load(tx_load),
      .clk_div_we(clk_div_we), .input_update(input_update),
      .debug_we(debug_we),
      .spi_instruction_done(spi_instruction_done),
      .instr_error(instr_error), .frame_abort(frame_abort)
   );

   always #5 system_clock = ~system_clock;

   int cyc = 0;
   always @(posedge system_clock) cyc <= cyc + 1;

   logic [7:0] mem [256];
   always @(posedge system_clock) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
   end

   int n_we = 0, n_re = 0, n_txl = 0, n_done = 0, n_err = 0;
   int n_cd = 0, n_iu = 0, n_db = 0, n_ab = 0;
   int we_cyc, re_cyc, txl_cyc, done_cyc, side_cyc, ab_cyc;
   logic [7:0] we_addr, we_data, txl_val;
   logic done_err;

   always @(negedge system_clock) begin
      if (mem_we) begin
         n_we <= n_we + 1; we_cyc <= cyc;
         we_addr <= mem_addr; we_data <= mem_wdata;
      end
      if (mem_re) begin n_re <= n_re + 1; re_cyc <= cyc; end
      if (tx_load) begin
         n_txl <= n_txl + 1; txl_cyc <= cyc; txl_val <= tx_byte;
      end
      if (spi_instruction_done) begin
         n_done <= n_done + 1; done_cyc <= cyc; done_err <= instr_error;
      end
      if (instr_error) n_err <= n_err + 1;
      if (clk_div_we) begin n_cd <= n_cd + 1; side_cyc <= cyc; end
      if (input_update) begin n_iu <= n_iu + 1; side_cyc <= cyc; end
      if (debug_we) begin n_db <= n_db + 1; side_cyc <= cyc; end
      if (frame_abort) begin n_ab <= n_ab + 1; ab_cyc <= cyc; end
   end

   int n_app = 0, n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_app++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] frame;
      logic        we, re, cd, iu, db, err;
      logic [7:0]  tx;
   } vec_t;

   function automatic vec_t mk(input logic [31:0] f, input logic [5:0] fl,
                               input logic [7:0] tx);
      vec_t v;
      v.frame = f;
      {v.we, v.re, v.cd, v.iu, v.db, v.err} = fl;
      v.tx = tx;
      return v;
   endfunction

   task automatic drive(input logic [7:0] b);
      @(posedge system_clock); #1;
      byte_valid = 1'b1;
      byte_in = b;
   endtask

   task automatic idle();
      @(posedge system_clock); #1;
      byte_valid = 1'b0;
   endtask

   function automatic logic [63:0] outs();
      return {31'd0, mem_addr, mem_wdata, tx_byte, mem_we, mem_re, tx_load,
              clk_div_we, input_update, debug_we, spi_instruction_done,
              instr_error, frame_abort};
   endfunction

   vec_t vt[13];
   int r, t, l;
   int b_we, b_re, b_txl, b_done, b_err, b_cd, b_iu, b_db, b_ab;

   task automatic snap();
      b_we = n_we; b_re = n_re; b_txl = n_txl; b_done = n_done;
      b_err = n_err; b_cd = n_cd; b_iu = n_iu; b_db = n_db; b_ab = n_ab;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vt[0]  = mk(32'h003401A5, 6'b100000, 8'h00);
      vt[1]  = mk(32'h45340000, 6'b010000, 8'hA5);
      vt[2]  = mk(32'h000605B6, 6'b101000, 8'h00);
      vt[3]  = mk(32'h00A309D8, 6'b100010, 8'h00);
      vt[4]  = mk(32'h000107BA, 6'b100100, 8'h00);
      vt[5]  = mk(32'h00070511, 6'b000001, 8'h00);
      vt[6]  = mk(32'h00A40122, 6'b000001, 8'h00);
      vt[7]  = mk(32'h00100C33, 6'b000001, 8'h00);
      vt[8]  = mk(32'h00A30177, 6'b100000, 8'h00);
      vt[9]  = mk(32'h00A30000, 6'b010000, 8'h77);
      vt[10] = mk(32'h00060944, 6'b000001, 8'h00);
      vt[11] = mk(32'h00A40000, 6'b000001, 8'h00);
      vt[12] = mk(32'h00000155, 6'b100000, 8'h00);

      repeat (3) @(posedge system_clock);
      @(negedge system_clock);
      chk("reset_outs", outs(), 64'd0);
      rst_n = 1'b1;
      @(negedge system_clock);
      chk("post_reset_outs", outs(), 64'd0);

      for (int i = 0; i < 13; i++) begin
         snap();
         for (int k = 0; k < 4; k++) begin
            drive(vt[i].frame[31 - 8 * k -: 8]);
            if (k == 2) r = cyc;
            if (k == 3) t = cyc;
         end
         idle();
         repeat (5) @(posedge system_clock);
         @(negedge system_clock);
         chk($sformatf("v%0d_we", i), 64'(n_we - b_we), 64'(vt[i].we));
         chk($sformatf("v%0d_done", i), 64'(n_done - b_done), 64'd1);
         chk($sformatf("v%0d_done_t", i), 64'(done_cyc), 64'(t + 1));
         chk($sformatf("v%0d_err", i), 64'(done_err), 64'(vt[i].err));
         chk($sformatf("v%0d_nerr", i), 64'(n_err - b_err), 64'(vt[i].err));
         chk($sformatf("v%0d_re", i), 64'(n_re - b_re), 64'(vt[i].re));
         chk($sformatf("v%0d_txl", i), 64'(n_txl - b_txl), 64'(vt[i].re));
         chk($sformatf("v%0d_side", i),
             64'({n_cd - b_cd, n_iu - b_iu, n_db - b_db}),
             64'({32'(vt[i].cd), 32'(vt[i].iu), 32'(vt[i].db)}));
         chk($sformatf("v%0d_abort", i), 64'(n_ab - b_ab), 64'd0);
         if (vt[i].we) begin
            chk($sformatf("v%0d_we_t", i), 64'(we_cyc), 64'(t + 1));
            chk($sformatf("v%0d_addr", i), 64'(we_addr),
                64'(vt[i].frame[23:16]));
            chk($sformatf("v%0d_wdata", i), 64'(we_data),
                64'(vt[i].frame[7:0]));
         end
         if (vt[i].cd || vt[i].iu || vt[i].db)
            chk($sformatf("v%0d_side_t", i), 64'(side_cyc), 64'(t + 1));
         if (vt[i].re) begin
            chk($sformatf("v%0d_re_t", i), 64'(re_cyc), 64'(r + 1));
            chk($sformatf("v%0d_txl_t", i), 64'(txl_cyc), 64'(r + 3));
            chk($sformatf("v%0d_tx", i), 64'(txl_val), 64'(vt[i].tx));
         end
      end

      // timeout after a partial frame
      snap();
      drive(8'h00);
      drive(8'h34);
      l = cyc;
      idle();
      for (int i = 0; i < 1200 && n_ab == b_ab; i++)
         @(negedge system_clock);
      chk("tmo_abort", 64'(n_ab - b_ab), 64'd1);
      chk("tmo_window", 64'((ab_cyc - l >= TMO) && (ab_cyc - l <= TMO + 3)),
          64'd1);
      chk("tmo_no_done", 64'(n_done - b_done), 64'd0);
      chk("tmo_no_we", 64'(n_we - b_we), 64'd0);
      snap();
      drive(8'h00); drive(8'h34); drive(8'h01); drive(8'h5A);
      t = cyc;
      idle();
      repeat (4) @(posedge system_clock);
      @(negedge system_clock);
      chk("tmo_next_we", 64'(n_we - b_we), 64'd1);
      chk("tmo_next_data", 64'({we_addr, we_data}), 64'h345A);
      chk("tmo_next_t", 64'(we_cyc), 64'(t + 1));

      // back-to-back frames, second MSB lands in S_EXEC
      snap();
      drive(8'h00); drive(8'h20); drive(8'h01); drive(8'h11);
      r = cyc;
      drive(8'h00); drive(8'h21); drive(8'h01); drive(8'h22);
      t = cyc;
      idle();
      repeat (4) @(posedge system_clock);
      @(negedge system_clock);
      chk("b2b_we", 64'(n_we - b_we), 64'd2);
      chk("b2b_done", 64'(n_done - b_done), 64'd2);
      chk("b2b_last_t", 64'(we_cyc), 64'(t + 1));
      chk("b2b_last", 64'({we_addr, we_data}), 64'h2122);
      chk("b2b_mem0", 64'(mem[8'h20]), 64'h11);
      chk("b2b_err", 64'(n_err - b_err), 64'd0);

      // reset after the instruction byte
      snap();
      drive(8'h00); drive(8'h34); drive(8'h01);
      @(posedge system_clock); #1;
      byte_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge system_clock);
      chk("rst_mid_outs", outs(), 64'd0);
      @(negedge system_clock);
      rst_n = 1'b1;
      repeat (3) @(negedge system_clock);
      chk("rst_mid_nostrobe",
          64'({n_we - b_we, n_done - b_done}), 64'd0);
      chk("rst_mid_noabort", 64'(n_ab - b_ab), 64'd0);
      snap();
      drive(8'h00); drive(8'h35); drive(8'h01); drive(8'h66);
      idle();
      repeat (4) @(posedge system_clock);
      @(negedge system_clock);
      chk("rst_after_we", 64'(n_we - b_we), 64'd1);
      chk("rst_after_data", 64'({we_addr, we_data}), 64'h3566);

      $display("== %0d vectors applied, %0d miscompares ==", n_app, n_bad);
      $finish;
   end

endmodule
